// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//
// Writer side of the redux instruction store. A DEPTH x DATA_W program RAM is
// filled from a byte stream (length byte first, then the program bytes) and
// read combinationally by the CPU fetch path. While a load is pending the CPU
// is held off through cpu_hold.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst          asynchronous active-high reset (RAM contents are kept)
//   start        one-cycle request to begin or restart a load
//   in_valid     in_data holds a byte
//   in_data      stream byte: length byte first, then program bytes
//   in_ready     loader can accept a byte this cycle
//   fetch_addr   CPU pc
//   fetch_instr  program RAM contents at fetch_addr (combinational)
//   cpu_hold     CPU must not advance pc or commit writes while high
//   busy         high while waiting for the length byte or loading bytes
//   wr_addr      next RAM address to be written
// ---------------------------------------------------------------------------
module prog_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              cpu_hold,
  output logic              busy,
  output logic [ADDR_W-1:0] wr_addr
);

  // The remaining-byte counter needs one extra bit so that a length byte of
  // zero can stand for a full DEPTH-byte program.
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    LEN,
    LOAD,
    RUN
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] wrAddr_q;
  logic [ADDR_W-1:0] wrAddr_d;
  logic [CNT_W-1:0]  remaining_q;
  logic [CNT_W-1:0]  remaining_d;
  logic [CNT_W-1:0]  lenCount_d;
  logic              cpuHold_q;
  logic              busy_q;
  logic              accept;
  logic              writeEn;
  logic              lastByte;

  logic [DATA_W-1:0] mem [DEPTH];

  // Handshake. busy_q is high exactly in LEN and LOAD, so it doubles as the
  // "receiving" qualifier; start always wins over a byte in the same cycle,
  // which guarantees a restart never swallows a stray stream byte.
  assign in_ready = busy_q && !start;
  assign accept   = in_ready && in_valid;
  assign writeEn  = accept && (state_q == LOAD);

  // Next values for the address and counter. The address wraps naturally at
  // DEPTH because DEPTH is 2^ADDR_W. A length byte of zero means DEPTH bytes.
  always_comb begin
    wrAddr_d    = wrAddr_q + 1'b1;
    remaining_d = remaining_q - 1'b1;
    lenCount_d  = CNT_W'(in_data);
    if (in_data == '0) begin
      lenCount_d = CNT_W'(DEPTH);
    end
  end

  // The byte being accepted in LOAD is the final one when exactly one byte
  // was still outstanding before the edge.
  assign lastByte = (remaining_q == CNT_W'(1));

  // Load FSM with registered cpu_hold/busy. A start request overrides every
  // state and rewinds the write pointer, but leaves previously written RAM
  // bytes in place. cpu_hold drops on the very edge that accepts the last
  // program byte, so the CPU may fetch it on the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wrAddr_q    <= '0;
      remaining_q <= '0;
      cpuHold_q   <= 1'b1;
      busy_q      <= 1'b0;
    end else if (start) begin
      state_q   <= LEN;
      wrAddr_q  <= '0;
      cpuHold_q <= 1'b1;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= IDLE;
        end
        LEN: begin
          if (accept) begin
            remaining_q <= lenCount_d;
            state_q     <= LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            wrAddr_q    <= wrAddr_d;
            remaining_q <= remaining_d;
            if (lastByte) begin
              state_q   <= RUN;
              cpuHold_q <= 1'b0;
              busy_q    <= 1'b0;
            end
          end
        end
        RUN: begin
          state_q <= RUN;
        end
        default: begin
          state_q   <= IDLE;
          cpuHold_q <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  // Program RAM write port. No reset: a reset in the middle of a load must
  // leave the bytes already written readable.
  always_ff @(posedge clk) begin
    if (writeEn) begin
      mem[wrAddr_q] <= in_data;
    end
  end

  // Asynchronous fetch port. A read of the address being written this cycle
  // returns the old contents; the new byte appears after the edge.
  assign fetch_instr = mem[fetch_addr];

  assign cpu_hold = cpuHold_q;
  assign busy     = busy_q;
  assign wr_addr  = wrAddr_q;

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
//
// Self-checking bench for prog_loader: a table of directed vectors for the
// basic and stalled loads, hand-written sequences for reset, start collision,
// full wrap and reload, and a randomized run against a behavioural model.
// ---------------------------------------------------------------------------
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] fetch_addr;
  logic [7:0] fetch_instr;
  logic       cpu_hold;
  logic       busy;
  logic [7:0] wr_addr;

  prog_loader #(.DEPTH(256), .ADDR_W(8), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .fetch_addr (fetch_addr),
    .fetch_instr(fetch_instr),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .wr_addr    (wr_addr)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  // Behavioural model: is the loader receiving, is it still waiting for the
  // length, how many program bytes are outstanding, where the next byte goes,
  // and which RAM bytes have a known value.
  bit          mBusy;
  bit          mHold;
  bit          mWantLen;
  int          mLeft;
  int          mAddr;
  byte unsigned mMem [256];
  bit          mKnown [256];

  // Samples taken by applyStimulus: before the edge and after it.
  logic       sReady;
  logic [7:0] sPreInstr;
  logic       sHold;
  logic       sBusy;
  logic [7:0] sWr;
  logic [7:0] sInstr;

  typedef struct {
    bit         s;
    bit         v;
    logic [7:0] d;
    logic [7:0] fa;
    bit         expReady;
    bit         expHold;
    bit         expBusy;
    logic [7:0] expWr;
    bit         chkF;
    logic [7:0] expF;
  } vec_t;

  vec_t vecs [15];

  // Compare one observed value against its required value and tally it.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  task automatic modelReset();
    mBusy    = 1'b0;
    mHold    = 1'b1;
    mWantLen = 1'b0;
    mLeft    = 0;
    mAddr    = 0;
  endtask

  // One clock edge of the loader as described by its rules.
  task automatic modelEdge(input bit s, input bit v, input logic [7:0] d);
    if (s) begin
      mBusy    = 1'b1;
      mHold    = 1'b1;
      mWantLen = 1'b1;
      mAddr    = 0;
    end else if (mBusy && v) begin
      if (mWantLen) begin
        mLeft    = (d == 8'd0) ? 256 : int'(d);
        mWantLen = 1'b0;
      end else begin
        mMem[mAddr]   = d;
        mKnown[mAddr] = 1'b1;
        mAddr         = (mAddr + 1) % 256;
        mLeft         = mLeft - 1;
        if (mLeft == 0) begin
          mBusy = 1'b0;
          mHold = 1'b0;
        end
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge, check the combinational
  // outputs before the rising edge, then the registered ones just after it.
  task automatic applyStimulus(input bit s, input bit v, input logic [7:0] d,
                               input logic [7:0] fa);
    @(negedge clk);
    start      = s;
    in_valid   = v;
    in_data    = d;
    fetch_addr = fa;
    #1;
    sReady    = in_ready;
    sPreInstr = fetch_instr;
    checkOutput("in_ready", sReady, mBusy && !s);
    if (mKnown[fa]) checkOutput("fetch_pre", sPreInstr, mMem[fa]);
    modelEdge(s, v, d);
    @(posedge clk);
    #1;
    sHold  = cpu_hold;
    sBusy  = busy;
    sWr    = wr_addr;
    sInstr = fetch_instr;
    checkOutput("cpu_hold", sHold, mHold);
    checkOutput("busy", sBusy, mBusy);
    checkOutput("wr_addr", sWr, mAddr);
    if (mKnown[fa]) checkOutput("fetch_post", sInstr, mMem[fa]);
  endtask

  // One-cycle asynchronous reset pulse; its effect is checked immediately.
  task automatic applyReset();
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_in_ready", in_ready, 1'b0);
    checkOutput("rst_cpu_hold", cpu_hold, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_wr_addr", wr_addr, 8'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    fetch_addr = 8'h00;
    modelReset();

    // Reset state.
    #1;
    checkOutput("init_in_ready", in_ready, 1'b0);
    checkOutput("init_cpu_hold", cpu_hold, 1'b1);
    checkOutput("init_busy", busy, 1'b0);
    checkOutput("init_wr_addr", wr_addr, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic load of 41 52 60, a byte offered in RUN, then the same stream
    // again with in_valid toggling.
    //           s  v  d      fa     rdy hold busy wr     chkF expF
    vecs[0]  = '{1, 0, 8'h00, 8'h00, 0,  1,   1,   8'd0, 0,   8'h00};
    vecs[1]  = '{0, 1, 8'h03, 8'h00, 1,  1,   1,   8'd0, 0,   8'h00};
    vecs[2]  = '{0, 1, 8'h41, 8'h00, 1,  1,   1,   8'd1, 1,   8'h41};
    vecs[3]  = '{0, 1, 8'h52, 8'h01, 1,  1,   1,   8'd2, 1,   8'h52};
    vecs[4]  = '{0, 1, 8'h60, 8'h02, 1,  0,   0,   8'd3, 1,   8'h60};
    vecs[5]  = '{0, 1, 8'h77, 8'h01, 0,  0,   0,   8'd3, 1,   8'h52};
    vecs[6]  = '{1, 1, 8'hAA, 8'h00, 0,  1,   1,   8'd0, 1,   8'h41};
    vecs[7]  = '{0, 1, 8'h03, 8'h00, 1,  1,   1,   8'd0, 1,   8'h41};
    vecs[8]  = '{0, 0, 8'h41, 8'h00, 1,  1,   1,   8'd0, 1,   8'h41};
    vecs[9]  = '{0, 1, 8'h41, 8'h00, 1,  1,   1,   8'd1, 1,   8'h41};
    vecs[10] = '{0, 0, 8'h55, 8'h01, 1,  1,   1,   8'd1, 1,   8'h52};
    vecs[11] = '{0, 1, 8'h52, 8'h01, 1,  1,   1,   8'd2, 1,   8'h52};
    vecs[12] = '{0, 0, 8'h99, 8'h02, 1,  1,   1,   8'd2, 1,   8'h60};
    vecs[13] = '{0, 1, 8'h60, 8'h02, 1,  0,   0,   8'd3, 1,   8'h60};
    vecs[14] = '{0, 1, 8'h11, 8'h02, 0,  0,   0,   8'd3, 1,   8'h60};

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].s, vecs[i].v, vecs[i].d, vecs[i].fa);
      checkOutput($sformatf("vec%0d_in_ready", i), sReady, vecs[i].expReady);
      checkOutput($sformatf("vec%0d_cpu_hold", i), sHold, vecs[i].expHold);
      checkOutput($sformatf("vec%0d_busy", i), sBusy, vecs[i].expBusy);
      checkOutput($sformatf("vec%0d_wr_addr", i), sWr, vecs[i].expWr);
      if (vecs[i].chkF) checkOutput($sformatf("vec%0d_fetch", i), sInstr, vecs[i].expF);
    end

    // Reset after two of four program bytes: written bytes survive.
    applyStimulus(1, 0, 8'h00, 8'h00);
    applyStimulus(0, 1, 8'h04, 8'h00);
    applyStimulus(0, 1, 8'h11, 8'h00);
    applyStimulus(0, 1, 8'h22, 8'h01);
    applyReset();
    fetch_addr = 8'h00;
    #1;
    checkOutput("rstmid_mem0", fetch_instr, 8'h11);
    fetch_addr = 8'h01;
    #1;
    checkOutput("rstmid_mem1", fetch_instr, 8'h22);

    // Start colliding with a valid byte in LOAD at wr_addr=2.
    applyStimulus(1, 0, 8'h00, 8'h02);
    applyStimulus(0, 1, 8'h05, 8'h02);
    applyStimulus(0, 1, 8'hB0, 8'h02);
    applyStimulus(0, 1, 8'hB1, 8'h02);
    checkOutput("coll_wr_before", sWr, 8'd2);
    applyStimulus(1, 1, 8'hAA, 8'h02);
    checkOutput("coll_in_ready", sReady, 1'b0);
    checkOutput("coll_wr_addr", sWr, 8'd0);
    checkOutput("coll_busy", sBusy, 1'b1);
    checkOutput("coll_not_written", sInstr, 8'h60);
    applyStimulus(0, 1, 8'h01, 8'h00);
    checkOutput("coll_len_wr", sWr, 8'd0);
    checkOutput("coll_len_hold", sHold, 1'b1);
    applyStimulus(0, 1, 8'hC3, 8'h00);
    checkOutput("coll_done_hold", sHold, 1'b0);
    checkOutput("coll_done_wr", sWr, 8'd1);
    checkOutput("coll_done_mem0", sInstr, 8'hC3);

    // Full wrap: length 0 loads 256 bytes.
    applyStimulus(1, 0, 8'h00, 8'h00);
    applyStimulus(0, 1, 8'h00, 8'h00);
    for (int i = 0; i < 256; i++) begin
      applyStimulus(0, 1, 8'(i), 8'(i));
      if (i == 254) checkOutput("wrap_hold_255", sHold, 1'b1);
    end
    checkOutput("wrap_wr_addr", sWr, 8'd0);
    checkOutput("wrap_cpu_hold", sHold, 1'b0);
    checkOutput("wrap_busy", sBusy, 1'b0);
    in_valid = 1'b0;
    for (int i = 0; i < 256; i++) begin
      fetch_addr = 8'(i);
      #1;
      checkOutput($sformatf("wrap_mem%0d", i), fetch_instr, 32'(i));
    end

    // Reload from RUN with read-during-write at address 0.
    applyStimulus(1, 0, 8'h00, 8'h00);
    checkOutput("reload_hold_start", sHold, 1'b1);
    applyStimulus(0, 1, 8'h01, 8'h00);
    checkOutput("reload_hold_len", sHold, 1'b1);
    applyStimulus(0, 1, 8'h9F, 8'h00);
    checkOutput("reload_rdw_old", sPreInstr, 8'h00);
    checkOutput("reload_rdw_new", sInstr, 8'h9F);
    checkOutput("reload_hold_done", sHold, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        applyReset();
      end else begin
        bit         rs;
        bit         rv;
        logic [7:0] rd;
        rs = ($urandom_range(0, 49) == 0);
        rv = ($urandom_range(0, 3) != 0);
        rd = mWantLen ? 8'($urandom_range(0, 6)) : 8'($urandom);
        applyStimulus(rs, rv, rd, 8'($urandom));
      end
    end

    start    = 1'b0;
    in_valid = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
